// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry constants and a ceiling-log2 helper.
// Used by param_fifo and its memory; later FIFO variants build on the same constants.
// No logic of its own.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;

  // Ceiling log2; returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for param_fifo: DEPTH x DATA_WIDTH.
// Write lands on the rising edge; read port is combinational from rd_addr.
// No flow control here; the FIFO controller decides when wr_en fires.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output.
// Standard mode: read data one cycle after an accepted pop; FWFT: head word visible combinationally.
// Producer sees full/almost_full, consumer sees empty/almost_empty; rejected requests set sticky error flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int AW        = clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_request,
  input  logic                  read_request,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty_s, full_s;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come only from the registered count, never from this cycle's requests
  assign empty_s      = (count_q == '0);
  assign full_s       = (count_q == CW'(DEPTH));
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance: in standard mode a pop frees the slot the same-cycle push lands in;
  // in FWFT mode the head is already presented, so a full FIFO refuses writes outright
  always_comb begin
    rd_acc = clk_en & ~flush & read_request & ~empty_s;
    wr_acc = clk_en & ~flush & write_request & (~full_s | ((FWFT == 0) & rd_acc));
  end

  // Pointer, occupancy and sticky-error next state; flush wins over requests
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clk_en) begin
      if (flush) begin
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        count_d     = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
        overflow_d  = overflow_q | (write_request & ~wr_acc);
        underflow_d = underflow_q | (read_request & ~rd_acc);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_q),
    .wr_data(write_data),
    .rd_addr(rd_ptr_q),
    .rd_data(mem_rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;

    // Output register: capture the popped word and pulse valid for one cycle
    always_comb begin
      read_data_d  = read_data_q;
      read_valid_d = read_valid_q;
      if (clk_en) begin
        read_valid_d = rd_acc;
        if (rd_acc) read_data_d = mem_rdata;
      end
    end

    // Read data / valid registers; read_data deliberately survives flush
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        read_data_q  <= '0;
        read_valid_q <= 1'b0;
      end else begin
        read_data_q  <= read_data_d;
        read_valid_q <= read_valid_d;
      end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
  end else begin : g_fwft
    // Head word shown directly; masked to zero while empty so stale RAM never leaks out
    assign read_data  = empty_s ? '0 : mem_rdata;
    assign read_valid = ~empty_s;
  end

endmodule
